// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: holds the fetch PC, reads one word per cycle
// from a combinational instruction memory, and buffers {pc, instr} pairs in a
// 2-entry FIFO for the decode stage. Branch redirects flush the buffer.
//
// Optional build macro FETCH_HALT_EN: when defined, fetching an all-zero word
// stops fetch (HALT state) until the next redirect or reset.
module fetch_ctrl #(
    parameter int unsigned N        = 32,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [5:0]   imem_addr,
    input  logic [N-1:0] imem_q,
    input  logic         PCSrc_F,
    input  logic [63:0]  PCBranch_F,
    input  logic         stall_F,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] instr_o,
    output logic [63:0]  pc_o,
    output logic         halted_o
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e       state_q;
    logic [63:0]  pc_q;
    logic [63:0]  fifo_pc_q    [2];
    logic [N-1:0] fifo_instr_q [2];
    logic         head_q;
    logic [1:0]   count_q;

    logic pop;
    logic room;
    logic fetch_ok;
    logic halt_hit;
    logic push;
    logic wr_idx;

    // Branch target is word aligned; the low byte-offset bits are dropped.
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = ^PCBranch_F[1:0];

    assign imem_addr = pc_q[7:2];

    // Handshake and push/pop decisions for this cycle.
    always_comb begin
        pop      = (count_q != 2'd0) && ready_i && !PCSrc_F;
        // A full FIFO still has room when the head leaves this cycle.
        room     = (count_q < 2'd2) || pop;
        fetch_ok = (state_q == StRun) && !PCSrc_F && !stall_F && room;
`ifdef FETCH_HALT_EN
        halt_hit = fetch_ok && (imem_q == '0);
`else
        halt_hit = 1'b0;
`endif
        push     = fetch_ok && !halt_hit;
        // Tail slot: head when empty or when full-and-popping, else the other slot.
        wr_idx   = head_q ^ count_q[0];
    end

    // Control state: PC, FIFO pointers/occupancy and run/halt FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            head_q  <= 1'b0;
            state_q <= StRun;
        end else if (PCSrc_F) begin
            pc_q    <= {PCBranch_F[63:2], 2'b00};
            count_q <= 2'd0;
            head_q  <= 1'b0;
            state_q <= StRun;
        end else begin
            if (push) begin
                pc_q <= pc_q + 64'd4;
            end
            if (halt_hit) begin
                state_q <= StHalt;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates the outputs.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc_q[wr_idx]    <= pc_q;
            fifo_instr_q[wr_idx] <= imem_q;
        end
    end

    // Head of FIFO, zeroed when empty.
    always_comb begin
        valid_o = (count_q != 2'd0);
        pc_o    = valid_o ? fifo_pc_q[head_q] : 64'd0;
        instr_o = valid_o ? fifo_instr_q[head_q] : '0;
    end

`ifdef FETCH_HALT_EN
    assign halted_o = (state_q == StHalt);
`else
    assign halted_o = 1'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 32, instruction word width in bits.
REQ-002 Parameter RESET_PC, default 64'h0, fetch address loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  6  word address to instruction memory; always equals pc[7:2].
REQ-006 imem_q  input  N  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 PCSrc_F  input  1  redirect request (branch taken) this cycle.
REQ-008 PCBranch_F  input  64  redirect target byte address.
REQ-009 stall_F  input  1  freeze fetch for this cycle.
REQ-010 valid_o  output  1  FIFO head holds a valid instruction.
REQ-011 ready_i  input  1  consumer accepts head this cycle.
REQ-012 instr_o  output  N  instruction at FIFO head.
REQ-013 pc_o  output  64  byte address of instr_o.
REQ-014 halted_o  output  1  fetch is in HALT state.

Function
REQ-015 Internal state: 64-bit pc, 2-entry FIFO of {pc, instr}, 2-bit count, FSM states RUN and HALT.
REQ-016 Pop: occurs when valid_o && ready_i and no redirect; head advances, count decrements.
REQ-017 Push: in RUN, no redirect, no stall_F, and (count<2 or pop this cycle); entry {pc, imem_q} written, pc <= pc+4.
REQ-018 Latency: word pushed in cycle t is visible at valid_o/instr_o/pc_o in cycle t+1 if FIFO was empty.
REQ-019 Push and pop in the same cycle at count 2 or 1: count unchanged, order preserved.
REQ-020 valid_o = (count != 0); instr_o and pc_o driven to 0 when count is 0.
REQ-021 Redirect (PCSrc_F=1): FIFO flushed (count <= 0), no push, no pop, pc <= {PCBranch_F[63:2], 2'b00}, state <= RUN.
REQ-022 Priority: reset > redirect > stall_F > normal push.
REQ-023 stall_F=1: pc held, no push; pops still permitted.
REQ-024 Address wrap: pc increments as full 64-bit; imem_addr uses pc[7:2] only, so 0xFC -> 0x100 maps word 63 -> word 0.
REQ-025 HALT state: no push, pc held, pops permitted; only redirect or reset leaves HALT.

Reset
REQ-026 On reset=1 at a clock edge: pc <= RESET_PC, count <= 0, state <= RUN, FIFO contents discarded.
REQ-027 Output values during/after reset: valid_o=0, instr_o=0, pc_o=0, halted_o=0, imem_addr=RESET_PC[7:2].
REQ-028 Reset asserted mid-operation overrides concurrent redirect, stall and pop in that cycle.

Configuration
REQ-029 Macro FETCH_HALT_EN: when defined, a fetched word equal to all-zero in RUN (with no redirect/stall and room to push) is not pushed; state <= HALT, pc held at that address; halted_o=1 in HALT.
REQ-030 When FETCH_HALT_EN is undefined: zero words are pushed like any instruction, HALT state unreachable, halted_o tied 0.

Verification
REQ-031 Image word0=0xf8000000, word1=0xf8008001; reset, ready_i=1 -> cycle 1 after release: valid_o=1, pc_o=0, instr_o=0xf8000000; next cycle pc_o=4, instr_o=0xf8008001.
REQ-032 ready_i=0 for 4 cycles from reset release -> count saturates at 2, imem_addr holds 2; ready_i=1 -> pc_o sequence 0,4,8 with no loss or duplicate.
REQ-033 FIFO full, PCSrc_F=1, PCBranch_F=0x3E -> next cycle valid_o=0, imem_addr=15; following cycle pc_o=0x3C; entries for 0,4 never appear.
REQ-034 Redirect to 0xFC, ready_i=1 -> pc_o 0xFC then 0x100 with instr_o equal to word 63 then word 0.
REQ-035 Image words 0..18 nonzero, word 19=0: with FETCH_HALT_EN last pc_o=0x48 then halted_o=1, valid_o=0; redirect to 0 -> halted_o=0, pc_o=0 refetched. Without macro pc_o=0x4C with instr_o=0.
REQ-036 stall_F=1 for 3 cycles with reset asserted in the second -> after reset release pc_o starts at 0, valid_o=0 in reset cycle and no stale entry emitted.
